pipe_dmem_responder: RTL and testbench

//  Data-memory responder for the pipelined CPU's load/store port. Accepts one

---
 rtl/pipe_dmem_responder.sv | 132 +++++++++++++
 tb/tb_pipe_dmem_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_dmem_responder.sv
// rtl/pipe_dmem_responder.sv - wait-stated data-memory responder for the CPU load/store port
// Single outstanding request, byte-masked word writes, err on misaligned/out-of-range access.
module pipe_dmem_responder #(
   parameter int          ADDR_WIDTH  = 6,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  be,
   output logic        ack,
   output logic [31:0] rdata,
   output logic        err,
   output logic        busy
);
   localparam int         DEPTH     = 2 ** ADDR_WIDTH;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        ack_q, ack_d;
   logic        err_q, err_d;
   logic        busy_q, busy_d;
   logic [31:0] rdata_q, rdata_d;

   logic [31:0] mem [DEPTH];

   // Word offset from the base; BASE_ADDR is a word-aligned byte address.
   logic [29:0]           off_w;
   logic [ADDR_WIDTH-1:0] idx;
   logic                  dec_err;
   logic                  ram_we;

   assign off_w   = addr_q[31:2] - BASE_ADDR[31:2];
   assign idx     = off_w[ADDR_WIDTH-1:0];
   assign dec_err = (addr_q[1:0] != 2'b00) || (|off_w[29:ADDR_WIDTH]);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      ack_d   = 1'b0;
      err_d   = err_q;
      rdata_d = rdata_q;
      ram_we  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               we_d    = we;
               addr_d  = addr;
               wdata_d = wdata;
               be_d    = be;
               cnt_d   = WAIT_INIT;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               ack_d   = 1'b1;
               err_d   = dec_err;
               rdata_d = (dec_err || we_q) ? 32'h0 : mem[idx];
               ram_we  = we_q && !dec_err;
               state_d = S_ACK;
            end
         end
         S_ACK: begin
            err_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            err_d   = 1'b0;
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         be_q    <= 4'h0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         rdata_q <= rdata_d;
      end
   end

   // RAM is not reset; an async reset forces IDLE, so a pending write can never land.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (be_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

   assign ack   = ack_q;
   assign err   = err_q;
   assign rdata = rdata_q;
   assign busy  = busy_q;
endmodule

// File: tb/tb_pipe_dmem_responder.sv
// tb/tb_pipe_dmem_responder.sv - scoreboard bench for pipe_dmem_responder
// Three instances (WAIT 1/0/3, one with a non-zero base) against a word-array reference model.
module tb_pipe_dmem_responder;
   localparam int N     = 3;
   localparam int DEPTH = 64;

   function automatic int wait_of(input int i);
      return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
   endfunction

   function automatic logic [31:0] base_of(input int i);
      return (i == 2) ? 32'h200 : 32'h0;
   endfunction

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        clrn;
   logic        req   [N];
   logic        we    [N];
   logic [31:0] addr  [N];
   logic [31:0] wdata [N];
   logic [3:0]  be    [N];
   logic        ack   [N];
   logic [31:0] rdata [N];
   logic        err   [N];
   logic        busy  [N];

   int   cyc = 0;
   int   checks = 0;
   int   fails = 0;
   logic ack_prev [N];
   exp_t exp_q [N][$];
   exp_t mon_e;
   logic [31:0] model [N][DEPTH];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < N; g++) begin : g_dut
      pipe_dmem_responder #(
         .ADDR_WIDTH (6),
         .WAIT_CYCLES(wait_of(g)),
         .BASE_ADDR  (base_of(g))
      ) u_dut (
         .clk  (clk),
         .clrn (clrn),
         .req  (req[g]),
         .we   (we[g]),
         .addr (addr[g]),
         .wdata(wdata[g]),
         .be   (be[g]),
         .ack  (ack[g]),
         .rdata(rdata[g]),
         .err  (err[g]),
         .busy (busy[g])
      );
   end

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", nm, i, act, exp, cyc);
      end
   endtask

   // Reference: the memory is a plain word array; errors come from byte-offset arithmetic.
   function automatic exp_t model_access(input int i, input logic w, input logic [31:0] a,
                                         input logic [31:0] d, input logic [3:0] b, input int due);
      exp_t        e;
      logic [31:0] off;
      int          wi;
      off     = a - base_of(i);
      e.due   = due;
      e.err   = (a % 4 != 0) || (off >= 32'(4 * DEPTH));
      e.rdata = 32'h0;
      if (!e.err) begin
         wi = int'(off / 4);
         if (w) begin
            for (int k = 0; k < 4; k++)
               if (b[k]) model[i][wi][8*k +: 8] = d[8*k +: 8];
         end else begin
            e.rdata = model[i][wi];
         end
      end
      return e;
   endfunction

   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (clrn === 1'b1 && ack[i] === 1'b1) begin
            chk("ack_single_cycle", i, 32'(ack_prev[i]), 32'h0);
            if (exp_q[i].size() == 0) begin
               chk("unexpected_ack", i, 32'h1, 32'h0);
            end else begin
               mon_e = exp_q[i].pop_front();
               chk("err", i, 32'(err[i]), 32'(mon_e.err));
               chk("rdata", i, rdata[i], mon_e.rdata);
               chk("ack_cycle", i, cyc, mon_e.due);
            end
         end
         ack_prev[i] = ack[i];
      end
   end

   task automatic wait_idle(input int i);
      int t = 0;
      while (busy[i] !== 1'b0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) chk("idle_timeout", i, 32'(t), 32'h0);
   endtask

   // Called at a negedge; returns at the negedge where ack is seen, with req dropped.
   task automatic access(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, input bit scramble);
      int t = 0;
      wait_idle(i);
      req[i] = 1'b1;
      we[i] = w;
      addr[i] = a;
      wdata[i] = d;
      be[i] = b;
      exp_q[i].push_back(model_access(i, w, a, d, b, cyc + wait_of(i) + 2));
      @(negedge clk);
      if (scramble) begin
         we[i] = ~w;
         addr[i] = $urandom;
         wdata[i] = $urandom;
         be[i] = 4'($urandom);
      end
      while (ack[i] !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) chk("ack_timeout", i, 32'(t), 32'h0);
      req[i] = 1'b0;
   endtask

   // req held high for n back-to-back reads of the same address.
   task automatic burst(input int i, input logic [31:0] a, input int n);
      int t = 0;
      int k = 0;
      wait_idle(i);
      req[i] = 1'b1;
      we[i] = 1'b0;
      addr[i] = a;
      for (int j = 0; j < n; j++)
         exp_q[i].push_back(model_access(i, 1'b0, a, 32'h0, 4'h0,
                                         cyc + wait_of(i) + 2 + j * (wait_of(i) + 3)));
      while (k < n && t < 200) begin
         @(negedge clk);
         t++;
         if (ack[i] === 1'b1) k++;
      end
      if (t >= 200) chk("burst_timeout", i, 32'(k), 32'(n));
      req[i] = 1'b0;
   endtask

   task automatic check_quiet(input string nm, input int i);
      chk({nm, "_ack"}, i, 32'(ack[i]), 32'h0);
      chk({nm, "_err"}, i, 32'(err[i]), 32'h0);
      chk({nm, "_rdata"}, i, rdata[i], 32'h0);
      chk({nm, "_busy"}, i, 32'(busy[i]), 32'h0);
   endtask

   initial begin
      logic [31:0] old_word;
      logic [31:0] a;
      int          off;
      clrn = 1'b0;
      for (int i = 0; i < N; i++) begin
         req[i] = 1'b0;
         we[i] = 1'b0;
         addr[i] = 32'h0;
         wdata[i] = 32'h0;
         be[i] = 4'h0;
         ack_prev[i] = 1'b0;
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < N; i++) check_quiet("reset", i);
      clrn = 1'b1;
      @(negedge clk);

      for (int i = 0; i < N; i++)
         for (int w = 0; w < DEPTH; w++)
            access(i, 1'b1, base_of(i) + 32'(4 * w), $urandom, 4'hF, 1'b0);

      access(0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 1'b0);
      access(0, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0);
      access(0, 1'b1, 32'hC, 32'h11223344, 4'hF, 1'b0);
      access(0, 1'b1, 32'hC, 32'hAABBCCDD, 4'b0101, 1'b0);
      access(0, 1'b0, 32'hC, 32'h0, 4'h0, 1'b0);
      access(0, 1'b1, 32'hC, 32'hFFFFFFFF, 4'b0000, 1'b0);
      access(0, 1'b0, 32'hC, 32'h0, 4'h0, 1'b0);
      access(0, 1'b0, 32'h6, 32'h0, 4'h0, 1'b0);
      access(0, 1'b1, 32'h6, 32'h12345678, 4'hF, 1'b0);
      access(0, 1'b0, 32'(4 * DEPTH), 32'h0, 4'h0, 1'b0);
      access(0, 1'b1, 32'(4 * DEPTH), 32'h12345678, 4'hF, 1'b0);
      access(0, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0);
      access(2, 1'b0, 32'h1FC, 32'h0, 4'h0, 1'b0);
      access(2, 1'b0, 32'h2FC, 32'h0, 4'h0, 1'b0);
      access(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b1);
      access(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1);

      burst(1, 32'h8, 4);
      burst(2, 32'h208, 4);
      burst(0, 32'h8, 3);

      wait_idle(0);
      old_word = model[0][4];
      req[0] = 1'b1;
      we[0] = 1'b1;
      addr[0] = 32'h10;
      wdata[0] = ~old_word;
      be[0] = 4'hF;
      @(negedge clk);
      clrn = 1'b0;
      #1;
      check_quiet("mid_reset", 0);
      @(negedge clk);
      req[0] = 1'b0;
      clrn = 1'b1;
      repeat (6) @(negedge clk);
      access(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);

      for (int i = 0; i < N; i++) begin
         for (int n = 0; n < 60; n++) begin
            off = int'($urandom_range(0, 4 * DEPTH + 15));
            a = base_of(i) + 32'(off & ~3);
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) a = base_of(i) - 32'h4;
            access(i, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom),
                   1'($urandom_range(0, 1)));
         end
      end

      repeat (8) @(negedge clk);
      for (int i = 0; i < N; i++) chk("queue_empty", i, 32'(exp_q[i].size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
